// File: rtl/lcd_num_writer_if.sv
// Host/display-RAM bundle for lcd_num_writer.
//   start/value/hex/line : host request, sampled by the writer in IDLE
//   busy/done            : job status back to the host
//   we/addr/din          : LCD1602 display RAM write port driven by the writer
interface lcd_num_writer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             hex;
    logic             line;
    logic             busy;
    logic             done;
    logic             we;
    logic [4:0]       addr;
    logic [7:0]       din;

    // Host side: issues requests, observes status and the RAM write stream.
    modport master (
        output start, value, hex, line,
        input  busy, done, we, addr, din
    );

    // Writer side.
    modport slave (
        input  start, value, hex, line,
        output busy, done, we, addr, din
    );
endinterface

// File: rtl/lcd_num_writer.sv
// lcd_num_writer: turns one binary value per request into a 16-character
// right-aligned ASCII field (leading-zero-blanked decimal or 0x-prefixed
// uppercase hex) and writes it, one byte per cycle, to line 0 (addr 0-15)
// or line 1 (addr 16-31) of the LCD1602 display RAM.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset; aborts any job in progress
//   bus   - lcd_num_writer_if.slave: start/value/hex/line in,
//           busy/done/we/addr/din out (all outputs registered)
module lcd_num_writer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_num_writer_if.slave    bus
);

    localparam int unsigned VAL_W   = 32;
    localparam int unsigned BCD_W   = 40;
    localparam int unsigned DIGITS  = 10;
    localparam int unsigned CHARS   = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned EXT_W   = 64;

    localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;
    localparam logic [CHAR_W-1:0] CH_ZERO  = 8'h30;
    localparam logic [CHAR_W-1:0] CH_X     = 8'h78;
    // 'A' - 10, so nibble 10..15 maps straight onto 'A'..'F'
    localparam logic [CHAR_W-1:0] CH_HEXA  = 8'h37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [VAL_W-1:0]    sr_q, sr_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                blank_q, blank_d;
    logic                hex_q, hex_d;
    logic                line_q, line_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CHAR_W-1:0]   din_q, din_d;

    // Character generation for the byte after the current one.
    logic [IDX_W-1:0]    nidx;
    logic [IDX_W-1:0]    k;
    logic [EXT_W-1:0]    bcd_ext;
    logic [EXT_W-1:0]    sr_ext;
    logic [3:0]          dig;
    logic [3:0]          nib;
    logic [CHAR_W-1:0]   ch;
    logic                blank_n;
    logic [BCD_W-1:0]    adj;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            blank_q   <= 1'b0;
            hex_q     <= 1'b0;
            line_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            blank_q   <= blank_d;
            hex_q     <= hex_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        blank_d   = blank_q;
        hex_d     = hex_q;
        line_d    = line_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;

        nidx      = IDX_W'(idx_q + 4'd1);
        k         = IDX_W'(4'd15 - nidx);
        bcd_ext   = EXT_W'(bcd_q);
        sr_ext    = EXT_W'(sr_q);
        dig       = bcd_ext[{k, 2'b00} +: 4];
        nib       = sr_ext[{k, 2'b00} +: 4];
        ch        = CH_SPACE;
        blank_n   = blank_q;
        adj       = bcd_q;

        // Outputs are registered, so the byte for idx+1 is prepared while idx
        // is on the bus; blank_q tracks the blanking state up to idx.
        if (hex_q) begin
            if (nidx == 4'd6) begin
                ch = CH_ZERO;
            end else if (nidx == 4'd7) begin
                ch = CH_X;
            end else if (nidx >= 4'd8) begin
                ch = (nib < 4'd10) ? CHAR_W'(CH_ZERO + CHAR_W'(nib))
                                   : CHAR_W'(CH_HEXA + CHAR_W'(nib));
            end
        end else if (nidx >= 4'd6) begin
            if (blank_q && (dig == 4'd0) && (nidx != 4'd15)) begin
                ch = CH_SPACE;
            end else begin
                ch      = CHAR_W'(CH_ZERO + CHAR_W'(dig));
                blank_n = 1'b0;
            end
        end

        // Double-dabble correction: nibbles >= 5 get +3 before the shift.
        for (int unsigned n = 0; n < DIGITS; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = 4'(bcd_q[4*n +: 4] + 4'd3);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d      = VAL_W'(bus.value[WIDTH-1:0]);
                    hex_d     = bus.hex;
                    line_d    = bus.line;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    blank_d   = 1'b1;
                    busy_d    = 1'b1;
                    if (bus.hex) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        addr_d  = {bus.line, 4'd0};
                        din_d   = CH_SPACE;
                    end else begin
                        state_d = CONV;
                    end
                end
            end

            CONV: begin
                busy_d    = 1'b1;
                bcd_d     = {adj[BCD_W-2:0], sr_q[VAL_W-1]};
                sr_d      = {sr_q[VAL_W-2:0], 1'b0};
                bit_cnt_d = CNT_W'(bit_cnt_q + 5'd1);
                if (bit_cnt_q == 5'(VAL_W - 1)) begin
                    // Column 0 is always a space, so the final shift need not
                    // have landed before the first byte is prepared.
                    state_d = WRITE;
                    we_d    = 1'b1;
                    addr_d  = {line_q, 4'd0};
                    din_d   = CH_SPACE;
                end
            end

            WRITE: begin
                busy_d = 1'b1;
                if (idx_q == IDX_W'(CHARS - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = nidx;
                    blank_d = blank_n;
                    we_d    = 1'b1;
                    addr_d  = {line_q, nidx};
                    din_d   = ch;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.we   = we_q;
    assign bus.addr = addr_q;
    assign bus.din  = din_q;

endmodule

// File: tb/tb_lcd_num_writer.sv
// Self-checking bench for lcd_num_writer: directed and random jobs checked
// cycle by cycle against a string-building reference model, plus start-while-
// busy and mid-write reset scenarios.
module tb_lcd_num_writer;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_num_writer_if #(.WIDTH(WIDTH)) bus ();

    lcd_num_writer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;
    logic [7:0] ram [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and capture the RAM write stream.
    task automatic tick();
        @(negedge clk);
        if (bus.we === 1'b1) begin
            ram[bus.addr] = bus.din;
            wr_cnt++;
        end
        if (bus.done === 1'b1) done_cnt++;
    endtask

    // Reference: build the 16-character field as a string, return column i.
    function automatic logic [7:0] ref_char(input logic [31:0] v, input logic h, input int i);
        logic [7:0] f [16];
        longint unsigned x;
        int pos;
        for (int j = 0; j < 16; j++) f[j] = 8'h20;
        if (h) begin
            f[6] = 8'h30;
            f[7] = 8'h78;
            for (int j = 0; j < 8; j++) begin
                x = (longint'(v) >> (4 * j)) & 64'hF;
                f[15 - j] = (x < 10) ? 8'(64'h30 + x) : 8'(64'h41 + x - 10);
            end
        end else begin
            x   = longint'(v);
            pos = 15;
            do begin
                f[pos] = 8'(64'h30 + (x % 10));
                x      = x / 10;
                pos--;
            end while (x != 0);
        end
        return f[i];
    endfunction

    // One job; abort_at > 0 asserts reset after that cycle's checks.
    task automatic run_job(input logic [31:0] v, input logic h, input logic l,
                           input bit noise, input int abort_at);
        int d;
        int ws;
        int wr0;
        int dn0;
        logic we_exp;
        d   = h ? 17 : 49;
        ws  = h ? 1 : 33;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        bus.value = v;
        bus.hex   = h;
        bus.line  = l;
        bus.start = 1'b1;
        for (int n = 1; n <= d; n++) begin
            tick();
            if (noise && (n == 4 || n == 39)) begin
                bus.start = 1'b1;
                bus.value = $urandom;
                bus.hex   = ~h;
                bus.line  = ~l;
            end else begin
                bus.start = 1'b0;
            end
            we_exp = (n >= ws) && (n < ws + 16);
            check("busy", 32'(bus.busy), 32'd1);
            check("done", 32'(bus.done), 32'(n == d));
            check("we", 32'(bus.we), 32'(we_exp));
            if (we_exp) begin
                check("addr", 32'(bus.addr), 32'({l, 4'(n - ws)}));
                check("din", 32'(bus.din), 32'(ref_char(v, h, n - ws)));
            end
            if (n == abort_at) begin
                rst_n = 1'b0;
                return;
            end
        end
        tick();
        check("busy_after", 32'(bus.busy), 32'd0);
        check("done_after", 32'(bus.done), 32'd0);
        check("write_count", 32'(wr_cnt - wr0), 32'd16);
        check("done_count", 32'(done_cnt - dn0), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("ram", 32'(ram[{l, 4'(i)}]), 32'(ref_char(v, h, i)));
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] abort_v;
        int dn0;
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        bus.hex   = 1'b0;
        bus.line  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed boundary values.
        run_job(32'd0, 1'b0, 1'b0, 1'b0, 0);
        run_job(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        run_job(32'd1200, 1'b0, 1'b0, 1'b0, 0);
        run_job(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 0);

        // start pulses while busy must be ignored; next job starts at once.
        run_job($urandom, 1'b0, 1'b0, 1'b1, 0);
        run_job(32'd7, 1'b0, 1'b1, 1'b0, 0);

        // Randomized jobs with varied magnitudes.
        for (int j = 0; j < 8; j++) begin
            rv = $urandom >> $urandom_range(0, 31);
            run_job(rv, 1'(j % 2 == 1 ? $urandom_range(0, 1) : 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
        end

        // Reset while writing idx 7 of a decimal job on line 0.
        for (int i = 0; i < 16; i++) ram[i] = 8'hEE;
        abort_v = 32'd1234567890;
        dn0     = done_cnt;
        run_job(abort_v, 1'b0, 1'b0, 1'b0, 40);
        tick();
        check("abort_we", 32'(bus.we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_addr", 32'(bus.addr), 32'd0);
        check("abort_din", 32'(bus.din), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_done", 32'(done_cnt - dn0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("abort_kept", 32'(ram[i]), 32'(ref_char(abort_v, 1'b0, i)));
        end
        for (int i = 8; i < 16; i++) begin
            check("abort_unwritten", 32'(ram[i]), 32'h0000_00EE);
        end
        run_job(32'h0000_00A5, 1'b1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_num_writer.md
Name: lcd_num_writer

Overview:
- Upstream feeder for the LCD1602 controller's 32-byte display RAM write port (`we`/`addr`/`din`).
- Converts one binary value per request into a 16-character right-aligned ASCII field.
  - Decimal mode: leading-zero blanked.
  - Hex mode: `0x`-prefixed.
- Writes the field, one byte per cycle, into line 0 (addresses 0-15) or line 1 (addresses 16-31).
- Uses a start/busy/done handshake, so a host can refresh a numeric readout without character-level work.

Parameters:
- WIDTH, 32, width of `value`; legal 1..32; zero-extended to 32 bits internally.

Ports:
- clk    input   1      system clock, all logic on rising edge
- rst_n  input   1      reset, synchronous, active-low
- start  input   1      request; sampled only in IDLE
- value  input   WIDTH  number to display; captured when start is accepted
- hex    input   1      1 = hex format, 0 = decimal; captured with value
- line   input   1      0 = addresses 0-15, 1 = addresses 16-31; captured with value
- busy   output  1      high in CONV, WRITE and DONE
- done   output  1      single-cycle pulse after the last byte is written
- we     output  1      display RAM write enable
- addr   output  5      display RAM address
- din    output  8      display RAM write data

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - busy=0, done=0, we=0, addr=0, din=0.
  - Internal shift, BCD, index and blank registers cleared.
  - Reset mid-operation aborts immediately; bytes already written stay in RAM; no done pulse.
- Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- FSM states: IDLE, CONV, WRITE, DONE.
  - IDLE: start=1 latches value/hex/line, clears bcd[39:0], bit counter=0 and char index=0, sets blank=1.
    - Next state CONV if hex=0, WRITE if hex=1.
  - CONV: double-dabble, one bit per cycle, for exactly 32 cycles.
    - Each cycle, every BCD nibble >=5 gets +3.
    - Then {bcd,sr} shifts left by 1 (sr MSB enters bcd[0]).
    - After cycle 32, go to WRITE.
  - WRITE: 16 cycles, idx=0..15.
    - we=1, addr={line, idx[3:0]}, din=char(idx).
    - idx=15 goes to DONE.
  - DONE: done=1, we=0 for one cycle, then IDLE.
- start while busy=1 is ignored: not queued, no effect on latched data.
- Latency from the start-accepting edge T:
  - Decimal: CONV T+1..T+32, WRITE T+33..T+48, done at T+49.
  - Hex: WRITE T+1..T+16, done at T+17.
  - New start accepted in the cycle after done (earliest T+50 dec / T+18 hex).
- Character map, decimal:
  - idx 0-5: 0x20 (space).
  - idx 6-15: BCD digit k = 9-(idx-6), most significant first, emitted as 0x30+digit.
  - Blanking: while blank=1 and the digit is 0 and idx<15, emit 0x20.
  - The first nonzero digit clears blank.
  - idx 15 is always a digit, so value 0 shows "0".
- Character map, hex:
  - idx 0-5: 0x20; idx 6: 0x30 ('0'); idx 7: 0x78 ('x').
  - idx 8-15: nibble (15-idx) of the 32-bit value, MS first, no blanking.
  - Nibble 0-9 emits 0x30+n; nibble A-F emits 0x41+(n-10), uppercase.
- Maximum 32-bit value 4294967295 fits in 10 digits; no overflow handling needed.
- The RAM read port (`dout`) is not used.
- Sharing the write port with other writers is the integrator's responsibility; this block assumes exclusive ownership while busy.

Test Plan:
- dec, line=0, value=0 -> bytes at addr 0..15 = fifteen 0x20 then 0x30; done at T+49; busy high T+1..T+49.
- dec, line=1, value=4294967295 -> addr 16..31 = six 0x20 then "4294967295" (0x34,0x32,0x39,0x34,0x39,0x36,0x37,0x32,0x39,0x35).
- dec, line=0, value=1200 -> addr 0..11 = 0x20, addr 12..15 = 0x31,0x32,0x30,0x30 (internal zeros kept).
- hex, line=1, value=0xDEADBEEF -> addr 16..31 = six 0x20, 0x30,0x78,0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46; done at T+17.
- start pulsed at T+5 and T+40 during a decimal job -> ignored; exactly 16 writes then one done; a start at T+50 is accepted.
- rst_n=0 during WRITE idx=7 -> next cycle we=0, busy=0, done never pulses; addr 8..15 unwritten; subsequent start behaves normally.
